// File: rtl/simple_mem_arbiter.sv
// Fetch/LSU arbiter onto one single-cycle memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is LSU priority.
module simple_mem_arbiter #(
   parameter int unsigned ADDR_W        = 32,
   parameter bit          RESET_PC_BIAS = 1'b0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              f_req_i,
   input  logic [ADDR_W-1:0] f_addr_i,
   output logic              f_gnt_o,
   output logic              f_rvalid_o,
   output logic [31:0]       f_rdata_o,
   input  logic              flush_i,
   input  logic              l_req_i,
   input  logic              l_we_i,
   input  logic [3:0]        l_be_i,
   input  logic [ADDR_W-1:0] l_addr_i,
   input  logic [31:0]       l_wdata_i,
   output logic              l_gnt_o,
   output logic              l_rvalid_o,
   output logic [31:0]       l_rdata_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RESP_F = 2'd1;
   localparam logic [1:0] RESP_L = 2'd2;

   logic [1:0] state_q, state_d;
   logic       drop_q, drop_d;
   logic       f_act, l_act;
   logic       f_win, l_win;
   logic       pick_f;

   // Requests are masked by reset so every output is quiet while rstn_i is low.
   assign f_act = rstn_i & f_req_i;
   assign l_act = rstn_i & l_req_i;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_gnt_q;

   // last_gnt_q: 1 = fetch won last, 0 = LSU won last.
   assign pick_f = ~last_gnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         last_gnt_q <= RESET_PC_BIAS;
      end else if (f_win | l_win) begin
         last_gnt_q <= f_win;
      end
   end
`else
   logic bias_unused;

   assign bias_unused = RESET_PC_BIAS;
   assign pick_f      = 1'b0;
`endif

   always_comb begin
      f_win = 1'b0;
      l_win = 1'b0;
      unique case (1'b1)
         f_act && l_act: begin
            f_win = pick_f;
            l_win = ~pick_f;
         end
         f_act && !l_act: f_win = 1'b1;
         !f_act && l_act: l_win = 1'b1;
         default: ;
      endcase
   end

   assign f_gnt_o = f_win;
   assign l_gnt_o = l_win;

   always_comb begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      unique case (1'b1)
         f_win: begin
            mem_read_o = 1'b1;
            mem_addr_o = f_addr_i;
            mem_be_o   = 4'hF;
         end
         l_win: begin
            mem_read_o  = ~l_we_i;
            mem_write_o = l_we_i;
            mem_addr_o  = l_addr_i;
            mem_wdata_o = l_wdata_i;
            mem_be_o    = l_be_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = IDLE;
      drop_d  = 1'b0;
      unique case (1'b1)
         f_win: begin
            state_d = RESP_F;
            drop_d  = flush_i;
         end
         l_win && !l_we_i: state_d = RESP_L;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // A fetch response is lost if flushed at grant time or while returning.
   assign f_rvalid_o = rstn_i & (state_q == RESP_F) & ~drop_q & ~flush_i;
   assign l_rvalid_o = rstn_i & (state_q == RESP_L);
   assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : 32'h0;
   assign l_rdata_o  = l_rvalid_o ? mem_rdata_i : 32'h0;

endmodule
